neuron_array_tm: RTL
====================

// Module: neuron_array_tm
// PURPOSE
//  Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one update datapath.
//  Successor to the single-neuron body: per-neuron state lives in a register file.
//  Each accepted update is one (neuron id, MAC sum) pair; the block emits one result per update.
//  Sits between the synapse/MAC stage and the spike router.
// PARAMETERS
//  N_NEURONS   16   number of neurons held in the state file
//  ID_W        4    neuron id width, must satisfy 2**ID_W >= N_NEURONS
//  DATA_WIDTH  8    membrane potential / MAC sum width (unsigned)
//  THRESH      15   firing threshold in IDLE
//  THRESH_HIGH 40   firing threshold in REL_REF
//  OVERSHOOT   70   post-spike vmem >= this selects ABS_REF, else REL_REF
//  MAX_VAL     100  vmem saturation ceiling, must be < 2**DATA_WIDTH
//  LEAK_IDLE   2    leak per update in IDLE
//  LEAK_REF    40   leak per update in REL_REF / ABS_REF
//  TH_INC      4    adaptive threshold increment per spike; used only with ADAPTIVE_THRESH_EN
//  TH_OFF_MAX  32   adaptive threshold offset ceiling; used only with ADAPTIVE_THRESH_EN
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset, asynchronous, active-low
//  clr_all      in   1           synchronous clear of all neuron state
//  in_valid     in   1           update request valid
//  in_ready     out  1           update request ready
//  in_id        in   ID_W        target neuron
//  in_mac_sum   in   DATA_WIDTH  integrated synaptic input
//  out_valid    out  1           result valid
//  out_ready    in   1           result consumer ready
//  out_id       out  ID_W        neuron id of the result
//  out_spike    out  1           neuron fired on this update
//  out_vmem     out  DATA_WIDTH  vmem after the update
// BEHAVIOUR
//  Reset: every neuron goes to IDLE with vmem=0 (and th_off=0). out_valid=0, out_id=0, out_spike=0, out_vmem=0.
//  Handshake
//   - in_ready = !clr_all && (!out_valid || out_ready).
//   - An update is accepted on the clk edge where in_valid && in_ready.
//   - Holding registers: out_valid stays high and out_* stay stable until out_ready is sampled high.
//  Latency: accept at edge k -> result on out_* after edge k.
//   - State is written at that same edge, so back-to-back updates to one id see fresh state.
//   - Full throughput of 1 update/cycle when out_ready=1.
//  in_id >= N_NEURONS: accepted, no state written, result has out_spike=0 and out_vmem=0.
//  Per-neuron state: st in {IDLE, REL_REF, ABS_REF}, vmem[DATA_WIDTH-1:0]. thr = THRESH (+ th_off).
//  Update rule (s is DATA_WIDTH+1 bits, no wrap):
//   IDLE:
//    - s = vmem + in_mac_sum; s = (s > LEAK_IDLE) ? s - LEAK_IDLE : 0; saturate s to MAX_VAL.
//    - If s >= thr: spike; st = (s >= OVERSHOOT) ? ABS_REF : REL_REF.
//    - vmem = s (the overshoot is kept).
//   REL_REF:
//    - s = vmem + in_mac_sum; s = (s > LEAK_REF) ? s - LEAK_REF : 0; saturate s to MAX_VAL.
//    - If s == 0: st = IDLE.
//    - Else if s >= THRESH_HIGH: spike, with the same ABS/REL branch on OVERSHOOT.
//   ABS_REF:
//    - in_mac_sum is ignored; vmem = (vmem > LEAK_REF) ? vmem - LEAK_REF : 0.
//    - If the result is 0: st = IDLE. Never spikes.
//  clr_all: at the next edge every neuron goes to IDLE with vmem=0 (and th_off=0).
//   - No update is accepted that cycle.
//   - A pending output result is kept.
//  Reset mid-stream drops any pending result; no partial state survives.
// CONFIGURATION
//  ADAPTIVE_THRESH_EN defined:
//   - Each neuron adds th_off[DATA_WIDTH-1:0]; thr = THRESH + th_off, compared at DATA_WIDTH+1 bits.
//   - On spike: th_off += TH_INC, saturating at TH_OFF_MAX.
//   - On an IDLE update without spike: th_off -= 1, floor 0.
//   - REL_REF / ABS_REF updates without a spike leave th_off unchanged.
//  ADAPTIVE_THRESH_EN undefined: no th_off storage; thr = THRESH fixed.
// STRUCTURE
//  Package snn_neuron_pkg holds:
//   - state encoding localparams NS_IDLE=2'd0, NS_REL_REF=2'd2, NS_ABS_REF=2'd3 (2'd1 reserved);
//   - a shared saturating add/leak helper function.
//  Sub-module neuron_lif_update (combinational):
//   - inputs: st, vmem, th_off, mac;
//   - outputs: next st, next vmem, next th_off, spike.
//  Top holds the state file, handshake and output registers.
// TESTING
//  1. Reset, then id=3 mac=10 -> vmem=8, spike=0. Then id=3 mac=10 -> vmem=16, spike=1, st=REL_REF.
//  2. id=5 mac=90 from IDLE -> vmem=88, spike=1. Next id=5 mac=0 -> vmem=48 (ABS_REF). Then 8, then 0 -> IDLE.
//  3. IDLE vmem=0, mac=255 -> vmem saturates at 100, spike=1, ABS_REF.
//  4. Same id on consecutive cycles with out_ready=1 -> second update uses the first result.
//     Then hold out_ready=0 for 3 cycles -> in_ready=0, out_* stable.
//  5. Drive clr_all mid-stream -> all ids read vmem=0 and state IDLE. Assert rst_n low with out_valid=1 -> out_valid=0 immediately.
//  6. With ADAPTIVE_THRESH_EN, after a spike on id=2 -> thr=19.
//     IDLE vmem=0, mac=19 -> vmem=17, no spike.

Source files
------------

// File: rtl/snn_neuron_pkg.sv
// rtl/snn_neuron_pkg.sv - shared state encoding and saturating add/leak helper for the LIF neuron array
package snn_neuron_pkg;

  localparam logic [1:0] NS_IDLE    = 2'd0;
  localparam logic [1:0] NS_REL_REF = 2'd2;
  localparam logic [1:0] NS_ABS_REF = 2'd3;

  // Working width for membrane arithmetic; wide enough that vmem + mac never wraps.
  localparam int CALC_W = 16;

  // (a + b), minus leak with a floor of zero, then clipped to ceil.
  function automatic logic [CALC_W-1:0] add_leak_sat(
    input logic [CALC_W-1:0] a,
    input logic [CALC_W-1:0] b,
    input logic [CALC_W-1:0] leak,
    input logic [CALC_W-1:0] ceil
  );
    logic [CALC_W-1:0] s;
    s = a + b;
    s = (s > leak) ? (s - leak) : '0;
    return (s > ceil) ? ceil : s;
  endfunction

endpackage

// File: rtl/neuron_lif_update.sv
// rtl/neuron_lif_update.sv - combinational LIF update for one neuron; adaptive threshold under ADAPTIVE_THRESH_EN
module neuron_lif_update
  import snn_neuron_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int THRESH      = 15,
  parameter int THRESH_HIGH = 40,
  parameter int OVERSHOOT   = 70,
  parameter int MAX_VAL     = 100,
  parameter int LEAK_IDLE   = 2,
`ifdef ADAPTIVE_THRESH_EN
  parameter int TH_INC      = 4,
  parameter int TH_OFF_MAX  = 32,
`endif
  parameter int LEAK_REF    = 40
) (
  input  logic [1:0]            st,
  input  logic [DATA_WIDTH-1:0] vmem,
`ifdef ADAPTIVE_THRESH_EN
  input  logic [DATA_WIDTH-1:0] th_off,
  output logic [DATA_WIDTH-1:0] th_off_next,
`endif
  input  logic [DATA_WIDTH-1:0] mac,
  output logic [1:0]            st_next,
  output logic [DATA_WIDTH-1:0] vmem_next,
  output logic                  spike
);

  logic [CALC_W-1:0] s_idle;
  logic [CALC_W-1:0] s_ref;
  logic [CALC_W-1:0] s_abs;
  logic [CALC_W-1:0] thr;

  assign s_idle = add_leak_sat(CALC_W'(vmem), CALC_W'(mac), CALC_W'(LEAK_IDLE), CALC_W'(MAX_VAL));
  assign s_ref  = add_leak_sat(CALC_W'(vmem), CALC_W'(mac), CALC_W'(LEAK_REF), CALC_W'(MAX_VAL));
  assign s_abs  = add_leak_sat(CALC_W'(vmem), '0, CALC_W'(LEAK_REF), CALC_W'(MAX_VAL));

`ifdef ADAPTIVE_THRESH_EN
  assign thr = CALC_W'(THRESH) + CALC_W'(th_off);
`else
  assign thr = CALC_W'(THRESH);
`endif

  // Per-state membrane update; the reserved encoding behaves like IDLE.
  always_comb begin
    st_next   = st;
    vmem_next = vmem;
    spike     = 1'b0;
    case (st)
      NS_REL_REF: begin
        vmem_next = s_ref[DATA_WIDTH-1:0];
        if (s_ref == '0) begin
          st_next = NS_IDLE;
        end else if (s_ref >= CALC_W'(THRESH_HIGH)) begin
          spike   = 1'b1;
          st_next = (s_ref >= CALC_W'(OVERSHOOT)) ? NS_ABS_REF : NS_REL_REF;
        end
      end
      NS_ABS_REF: begin
        vmem_next = s_abs[DATA_WIDTH-1:0];
        if (s_abs == '0) st_next = NS_IDLE;
      end
      default: begin
        vmem_next = s_idle[DATA_WIDTH-1:0];
        st_next   = NS_IDLE;
        if (s_idle >= thr) begin
          spike   = 1'b1;
          st_next = (s_idle >= CALC_W'(OVERSHOOT)) ? NS_ABS_REF : NS_REL_REF;
        end
      end
    endcase
  end

`ifdef ADAPTIVE_THRESH_EN
  logic [CALC_W-1:0] th_sum;
  assign th_sum = CALC_W'(th_off) + CALC_W'(TH_INC);

  // Threshold offset climbs on spikes and relaxes by one on quiet IDLE updates.
  always_comb begin
    th_off_next = th_off;
    if (spike) begin
      th_off_next = (th_sum > CALC_W'(TH_OFF_MAX)) ? DATA_WIDTH'(TH_OFF_MAX) : th_sum[DATA_WIDTH-1:0];
    end else if (st != NS_REL_REF && st != NS_ABS_REF && th_off != '0) begin
      th_off_next = th_off - 1'b1;
    end
  end
`endif

endmodule

// File: rtl/neuron_array_tm.sv
// rtl/neuron_array_tm.sv - time-multiplexed LIF neuron array with state file and output holding registers; ADAPTIVE_THRESH_EN adds per-neuron threshold offsets
module neuron_array_tm
  import snn_neuron_pkg::*;
#(
  parameter int N_NEURONS   = 16,
  parameter int ID_W        = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int THRESH      = 15,
  parameter int THRESH_HIGH = 40,
  parameter int OVERSHOOT   = 70,
  parameter int MAX_VAL     = 100,
  parameter int LEAK_IDLE   = 2,
  parameter int LEAK_REF    = 40,
  parameter int TH_INC      = 4,
  parameter int TH_OFF_MAX  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_all,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ID_W-1:0]       in_id,
  input  logic [DATA_WIDTH-1:0] in_mac_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_spike,
  output logic [DATA_WIDTH-1:0] out_vmem
);

  logic [1:0]            st_q   [N_NEURONS];
  logic [DATA_WIDTH-1:0] vmem_q [N_NEURONS];

  logic                  accept;
  logic                  id_ok;
  logic [ID_W-1:0]       rd_idx;
  logic [1:0]            st_next;
  logic [DATA_WIDTH-1:0] vmem_next;
  logic                  spike;

  assign in_ready = !clr_all && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign id_ok    = {1'b0, in_id} < (ID_W + 1)'(N_NEURONS);
  assign rd_idx   = id_ok ? in_id : '0;

`ifdef ADAPTIVE_THRESH_EN
  logic [DATA_WIDTH-1:0] th_q [N_NEURONS];
  logic [DATA_WIDTH-1:0] th_next;

  // Threshold offset file: cleared with the rest of the neuron state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) th_q[i] <= '0;
    end else if (clr_all) begin
      for (int i = 0; i < N_NEURONS; i++) th_q[i] <= '0;
    end else if (accept && id_ok) begin
      th_q[rd_idx] <= th_next;
    end
  end
`endif

  neuron_lif_update #(
    .DATA_WIDTH  (DATA_WIDTH),
    .THRESH      (THRESH),
    .THRESH_HIGH (THRESH_HIGH),
    .OVERSHOOT   (OVERSHOOT),
    .MAX_VAL     (MAX_VAL),
    .LEAK_IDLE   (LEAK_IDLE),
`ifdef ADAPTIVE_THRESH_EN
    .TH_INC      (TH_INC),
    .TH_OFF_MAX  (TH_OFF_MAX),
`endif
    .LEAK_REF    (LEAK_REF)
  ) u_update (
    .st          (st_q[rd_idx]),
    .vmem        (vmem_q[rd_idx]),
`ifdef ADAPTIVE_THRESH_EN
    .th_off      (th_q[rd_idx]),
    .th_off_next (th_next),
`endif
    .mac         (in_mac_sum),
    .st_next     (st_next),
    .vmem_next   (vmem_next),
    .spike       (spike)
  );

  // Neuron state file: written at the accept edge so the next update sees fresh state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        st_q[i]   <= NS_IDLE;
        vmem_q[i] <= '0;
      end
    end else if (clr_all) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        st_q[i]   <= NS_IDLE;
        vmem_q[i] <= '0;
      end
    end else if (accept && id_ok) begin
      st_q[rd_idx]   <= st_next;
      vmem_q[rd_idx] <= vmem_next;
    end
  end

  // Result holding registers: load on accept, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_spike <= 1'b0;
      out_vmem  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_id    <= in_id;
      out_spike <= id_ok && spike;
      out_vmem  <= id_ok ? vmem_next : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
